// File: rtl/moore_ssm_seq_ctrl.sv
// Round-robin sequencer for the shared moore_ssm detector: grant, clear, shift pattern LSB-first, count z1 hits.
// Optional SSM_ABORT_EN adds abort_i/aborted_o to cut a run short from CLR, RUN or DRAIN.
//   state   | meaning
//   IDLE    | arbitrate requests, latch winner's pattern/length
//   CLR     | hold detector in reset, clear hit counter
//   RUN     | shift one pattern bit per cycle into ssm_x1
//   DRAIN   | one extra z1 sample, capture ssm_y
//   DONE    | done pulse with hit count and final y
module moore_ssm_seq_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_i,
  input  logic [PAT_W-1:0] pat0_i,
  input  logic [3:0]       len0_i,
  input  logic [PAT_W-1:0] pat1_i,
  input  logic [3:0]       len1_i,
  output logic [1:0]       gnt_o,
  output logic             busy_o,
  output logic             ssm_rst_n_o,
  output logic             ssm_x1_o,
  input  logic             ssm_z1_i,
  input  logic [2:0]       ssm_y_i,
  output logic             done_o,
  output logic             done_id_o,
  output logic [CNT_W-1:0] hits_o,
  output logic [2:0]       last_y_o
`ifdef SSM_ABORT_EN
  ,
  input  logic             abort_i,
  output logic             aborted_o
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state_q;
  logic             rr_q;
  logic             id_q;
  logic [PAT_W-1:0] pat_q;
  logic [3:0]       rem_q;
  logic [CNT_W-1:0] hit_q;
  logic [CNT_W-1:0] hit_d;
  logic             busy_q, ssm_rst_n_q, x1_q, done_q, done_id_q;
  logic [CNT_W-1:0] hits_q;
  logic [2:0]       last_y_q;
  logic             win_id;
  logic [3:0]       len_sel, len_clamp;
  logic             abort_w;

`ifdef SSM_ABORT_EN
  logic aborted_q;
  assign abort_w   = abort_i;
  assign aborted_o = aborted_q;
`else
  assign abort_w = 1'b0;
`endif

  assign busy_o      = busy_q;
  assign ssm_rst_n_o = ssm_rst_n_q;
  assign ssm_x1_o    = x1_q;
  assign done_o      = done_q;
  assign done_id_o   = done_id_q;
  assign hits_o      = hits_q;
  assign last_y_o    = last_y_q;

  always_comb begin
    win_id = 1'b0;
    case (req_i)
      2'b10:   win_id = 1'b1;
      2'b11:   win_id = rr_q;
      default: win_id = 1'b0;
    endcase
    gnt_o = 2'b00;
    if (state_q == S_IDLE && req_i != 2'b00) gnt_o = win_id ? 2'b10 : 2'b01;
    len_sel   = win_id ? len1_i : len0_i;
    len_clamp = (int'(len_sel) > PAT_W) ? 4'(PAT_W) : len_sel;
    hit_d = hit_q;
    if ((state_q == S_RUN || state_q == S_DRAIN) && ssm_z1_i && hit_q != '1)
      hit_d = hit_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b0;
      id_q        <= 1'b0;
      pat_q       <= '0;
      rem_q       <= '0;
      hit_q       <= '0;
      busy_q      <= 1'b0;
      ssm_rst_n_q <= 1'b1;
      x1_q        <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= 1'b0;
      hits_q      <= '0;
      last_y_q    <= 3'b001;
`ifdef SSM_ABORT_EN
      aborted_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (abort_w && (state_q == S_CLR || state_q == S_RUN || state_q == S_DRAIN)) begin
        // Counter is being cleared in CLR, so an abort there reports zero hits.
        state_q     <= S_DONE;
        ssm_rst_n_q <= 1'b1;
        x1_q        <= 1'b0;
        done_q      <= 1'b1;
        done_id_q   <= id_q;
        hits_q      <= (state_q == S_CLR) ? '0 : hit_d;
        last_y_q    <= ssm_y_i;
`ifdef SSM_ABORT_EN
        aborted_q   <= 1'b1;
`endif
      end else begin
        case (state_q)
          S_IDLE: if (req_i != 2'b00) begin
            state_q     <= S_CLR;
            busy_q      <= 1'b1;
            ssm_rst_n_q <= 1'b0;
            pat_q       <= win_id ? pat1_i : pat0_i;
            rem_q       <= len_clamp;
            id_q        <= win_id;
            if (req_i == 2'b11) rr_q <= ~win_id;
          end
          S_CLR: begin
            hit_q       <= '0;
            ssm_rst_n_q <= 1'b1;
            if (rem_q == 4'd0) begin
              state_q <= S_DRAIN;
            end else begin
              state_q <= S_RUN;
              x1_q    <= pat_q[0];
              pat_q   <= pat_q >> 1;
            end
          end
          S_RUN: begin
            hit_q <= hit_d;
            if (rem_q == 4'd1) begin
              state_q <= S_DRAIN;
              x1_q    <= 1'b0;
            end else begin
              rem_q <= rem_q - 4'd1;
              x1_q  <= pat_q[0];
              pat_q <= pat_q >> 1;
            end
          end
          S_DRAIN: begin
            state_q   <= S_DONE;
            hit_q     <= hit_d;
            hits_q    <= hit_d;
            last_y_q  <= ssm_y_i;
            done_q    <= 1'b1;
            done_id_q <= id_q;
`ifdef SSM_ABORT_EN
            aborted_q <= 1'b0;
`endif
          end
          S_DONE: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_moore_ssm_seq_ctrl.sv
// Bench for moore_ssm_seq_ctrl: behavioural "111" detector plus directed and random runs checked against
// a run-level reference model; a second instance with CNT_W=2 exercises hit saturation.
module tb_moore_ssm_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] req = 2'b00;
  logic [7:0] pat0 = '0, pat1 = '0;
  logic [3:0] len0 = '0, len1 = '0;
  logic [1:0] gnt, gnt2;
  logic busy, busy2, ssm_rst_n, ssm_rst_n2, ssm_x1, ssm_x12, done, done2, done_id, done_id2;
  logic [3:0] hits;
  logic [1:0] hits2;
  logic [2:0] last_y, last_y2;
  logic ssm_z1;
  logic [2:0] ssm_y;
`ifdef SSM_ABORT_EN
  logic abort = 1'b0;
  logic aborted, aborted2;
`endif

  moore_ssm_seq_ctrl #(.PAT_W(8), .CNT_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .pat0_i(pat0), .len0_i(len0), .pat1_i(pat1), .len1_i(len1),
    .gnt_o(gnt), .busy_o(busy), .ssm_rst_n_o(ssm_rst_n), .ssm_x1_o(ssm_x1), .ssm_z1_i(ssm_z1),
    .ssm_y_i(ssm_y), .done_o(done), .done_id_o(done_id), .hits_o(hits), .last_y_o(last_y)
`ifdef SSM_ABORT_EN
    , .abort_i(abort), .aborted_o(aborted)
`endif
  );

  moore_ssm_seq_ctrl #(.PAT_W(8), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_i(req), .pat0_i(pat0), .len0_i(len0), .pat1_i(pat1), .len1_i(len1),
    .gnt_o(gnt2), .busy_o(busy2), .ssm_rst_n_o(ssm_rst_n2), .ssm_x1_o(ssm_x12), .ssm_z1_i(ssm_z1),
    .ssm_y_i(ssm_y), .done_o(done2), .done_id_o(done_id2), .hits_o(hits2), .last_y_o(last_y2)
`ifdef SSM_ABORT_EN
    , .abort_i(abort), .aborted_o(aborted2)
`endif
  );

  // Detector stand-in: counts consecutive ones (capped at 3); z1 when three in a row.
  logic [1:0] ones = 2'd0;
  always @(posedge clk or negedge ssm_rst_n)
    if (!ssm_rst_n) ones <= 2'd0;
    else            ones <= ssm_x1 ? ((ones == 2'd3) ? 2'd3 : 2'(ones + 2'd1)) : 2'd0;
  assign ssm_z1 = (ones == 2'd3);
  always_comb begin
    ssm_y = 3'b001;
    case (ones)
      2'd1: ssm_y = 3'b010;
      2'd2: ssm_y = 3'b100;
      2'd3: ssm_y = 3'b111;
      default: ssm_y = 3'b001;
    endcase
  end

  int n_checks = 0;
  int n_fails = 0;
  int ptr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic int exp_hits(input logic [7:0] p, input int len, input int maxv);
    int c = 0;
    for (int k = 3; k <= len; k++)
      if (p[k-3] && p[k-2] && p[k-1]) c++;
    return (c > maxv) ? maxv : c;
  endfunction

  function automatic logic [2:0] exp_y(input logic [7:0] p, input int len);
    int t = 0;
    bit run = 1'b1;
    for (int i = len - 1; i >= 0; i--) begin
      if (run && p[i] && t < 3) t++;
      else run = 1'b0;
    end
    case (t)
      1: return 3'b010;
      2: return 3'b100;
      3: return 3'b111;
      default: return 3'b001;
    endcase
  endfunction

  // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after DONE.
  task automatic run(input logic [1:0] r, input logic [7:0] p0, input logic [3:0] l0,
                     input logic [7:0] p1, input logic [3:0] l1);
    int w, len;
    logic [7:0] p;
    logic [3:0] l;
    logic ex;
    req = r; pat0 = p0; len0 = l0; pat1 = p1; len1 = l1;
    #1;
    if (r == 2'b01) w = 0;
    else if (r == 2'b10) w = 1;
    else begin w = ptr; ptr = 1 - ptr; end
    p = (w == 1) ? p1 : p0;
    l = (w == 1) ? l1 : l0;
    len = (l > 4'd8) ? 8 : int'(l);
    chk("gnt", 32'(gnt), 32'(2'b01 << w));
    chk("gnt2", 32'(gnt2), 32'(2'b01 << w));
    chk("busy_idle", 32'(busy), 0);
    @(negedge clk);
    req = 2'b00;
    for (int n = 1; n <= len + 3; n++) begin
      ex = (n >= 2 && n <= len + 1) ? p[n-2] : 1'b0;
      chk("ssm_x1", 32'(ssm_x1), 32'(ex));
      chk("ssm_x1_2", 32'(ssm_x12), 32'(ex));
      chk("ssm_rst_n", 32'(ssm_rst_n), 32'(n != 1));
      chk("ssm_rst_n2", 32'(ssm_rst_n2), 32'(n != 1));
      chk("busy", 32'(busy), 1);
      chk("busy2", 32'(busy2), 1);
      chk("done", 32'(done), 32'(n == len + 3));
      chk("done2", 32'(done2), 32'(n == len + 3));
      if (n == len + 3) begin
        chk("done_id", 32'(done_id), 32'(w));
        chk("done_id2", 32'(done_id2), 32'(w));
        chk("hits", 32'(hits), 32'(exp_hits(p, len, 15)));
        chk("hits_sat", 32'(hits2), 32'(exp_hits(p, len, 3)));
        chk("last_y", 32'(last_y), 32'(exp_y(p, len)));
        chk("last_y2", 32'(last_y2), 32'(exp_y(p, len)));
`ifdef SSM_ABORT_EN
        chk("aborted", 32'(aborted), 0);
        chk("aborted2", 32'(aborted2), 0);
`endif
      end
      @(negedge clk);
    end
    chk("busy_after", 32'(busy), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ssm_rst_n", 32'(ssm_rst_n), 1);
    chk("rst_x1", 32'(ssm_x1), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_done_id", 32'(done_id), 0);
    chk("rst_hits", 32'(hits), 0);
    chk("rst_last_y", 32'(last_y), 32'(3'b001));
    rst_n = 1'b1;
    @(negedge clk);

    run(2'b01, 8'h0F, 4'd8, 8'h00, 4'd0);
    run(2'b10, 8'h00, 4'd0, 8'hFF, 4'd8);
    run(2'b01, 8'h55, 4'd8, 8'h00, 4'd0);
    run(2'b01, 8'hFF, 4'd0, 8'h00, 4'd0);
    run(2'b01, 8'hF7, 4'd12, 8'h00, 4'd0);
    run(2'b11, 8'hFF, 4'd8, 8'hFF, 4'd6);
    run(2'b11, 8'hFF, 4'd8, 8'hFF, 4'd6);
    run(2'b11, 8'hFF, 4'd8, 8'hFF, 4'd6);
    run(2'b11, 8'hFF, 4'd8, 8'hFF, 4'd6);

    // Reset during RUN cycle 3: everything back to reset values at once, no done.
    req = 2'b01; pat0 = 8'hFF; len0 = 4'd8;
    @(negedge clk);
    req = 2'b00;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_hits", 32'(hits), 0);
    chk("mid_rst_x1", 32'(ssm_x1), 0);
    chk("mid_rst_ssm_rst_n", 32'(ssm_rst_n), 1);
    chk("mid_rst_last_y", 32'(last_y), 32'(3'b001));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_no_done", 32'(done), 0);
    end
    rst_n = 1'b1;
    ptr = 0;
    @(negedge clk);
    run(2'b01, 8'h0F, 4'd8, 8'h00, 4'd0);

`ifdef SSM_ABORT_EN
    req = 2'b01; pat0 = 8'hFF; len0 = 4'd8;
    @(negedge clk);
    req = 2'b00;
    repeat (6) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_done", 32'(done), 1);
    chk("abort_flag", 32'(aborted), 1);
    chk("abort_hits", 32'(hits), 3);
    chk("abort_hits2", 32'(hits2), 3);
    chk("abort_last_y", 32'(last_y), 32'(3'b111));
    chk("abort_flag2", 32'(aborted2), 1);
    @(negedge clk);
    chk("abort_idle", 32'(busy), 0);
`endif

    for (int i = 0; i < 40; i++)
      run(2'($urandom_range(1, 3)), 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)),
          8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/moore_ssm_seq_ctrl.md
Name: moore_ssm_seq_ctrl

Overview:
Sequencer and arbiter for the shared moore_ssm sequence detector. It grants the detector to one of two requesters in round-robin order and clears the detector. It then shifts the winner's pattern into ssm_x1 one bit per clock, LSB first. Finally it counts cycles with z1 high and reports the hit count plus final y code with a done pulse.

Parameters:
PAT_W, 8, pattern width in bits (max run length).
CNT_W, 4, hit counter width; counter saturates.

Ports:
clk  input  1  clock.
rst_n  input  1  reset, asynchronous, active-low.
req  input  2  per-requester run request; held high until granted.
pat0  input  PAT_W  requester 0 pattern; bit 0 is shifted first.
len0  input  4  requester 0 run length in bits.
pat1  input  PAT_W  requester 1 pattern.
len1  input  4  requester 1 run length.
gnt  output  2  one-hot grant pulse (one cycle).
busy  output  1  run in progress.
ssm_rst_n  output  1  clear to detector, active-low; driven directly from a state flop, glitch-free.
ssm_x1  output  1  serial bit to detector.
ssm_z1  input  1  detector z1.
ssm_y  input  3  detector y.
done  output  1  one-cycle completion pulse.
done_id  output  1  requester whose run completed; valid with done.
hits  output  CNT_W  z1-high cycle count of the last run; held until the next done.
last_y  output  3  ssm_y captured in DRAIN; held until the next done.

Behaviour:
- Reset values: gnt=0, busy=0, ssm_rst_n=1, ssm_x1=0, done=0, done_id=0, hits=0, last_y=3'b001, RR pointer=0, state=IDLE.
- States: IDLE, CLR, RUN, DRAIN, DONE.
- IDLE:
  - If req!=0, gnt is asserted combinationally in the same cycle to the winner.
  - The winner's pat and len are latched; next state is CLR.
  - Arbitration: a lone request wins. If both request, the requester selected by the RR pointer wins, and the pointer then points to the other requester.
  - req is ignored outside IDLE.
- CLR: 1 cycle, ssm_rst_n=0, hit counter cleared. Next state is RUN, or DRAIN if the latched length is 0.
- RUN: len cycles. In cycle k (k=0..len-1), ssm_x1 = pat[k]. Next state is DRAIN after cycle len-1.
- Length clamp: a latched length greater than PAT_W is clamped to PAT_W.
- DRAIN: 1 cycle, ssm_x1=0. ssm_y is captured into last_y.
- Hit counting: in RUN and DRAIN, the counter increments when ssm_z1=1, saturating at 2^CNT_W-1. The detector is in its cleared state during RUN cycle 0, so z1=0 in that cycle.
- DONE: 1 cycle. done=1, done_id=winner, hits is updated from the counter. Next state is IDLE.
- busy=1 in CLR, RUN, DRAIN and DONE.
- ssm_x1=0 outside RUN.
- Latency: from the gnt cycle to the done cycle is len+3 cycles (len after clamp).
- A new grant is possible in the cycle after DONE (back-to-back runs).
- Reset mid-run: all registers return to reset values immediately and the run is discarded; no done pulse is produced.

Optional Feature:
SSM_ABORT_EN.
- Defined: adds input abort (1b) and output aborted (1b).
  - abort=1 in CLR, RUN or DRAIN forces DONE on the next cycle.
  - done and aborted are then both 1; hits holds the count so far; last_y holds ssm_y sampled in the abort cycle.
  - aborted=0 on normal completion. abort is ignored in IDLE and DONE.
- Undefined: neither port exists, and runs always complete.

Test Plan:
- Requester 0, pat0=8'h0F, len0=8 -> gnt=01, done 11 cycles after gnt, hits=2, last_y=3'b001, done_id=0.
- pat=8'hFF, len=8 -> hits=6, last_y=3'b111. Same stimulus with CNT_W=2 -> hits=3 (saturated).
- pat=8'h55, len=8 -> hits=0, last_y=3'b001. len=0 -> done 3 cycles after gnt, hits=0, last_y=3'b001. len=12 -> behaves as len=8.
- req=11 held from reset -> first gnt=01 (done_id=0), second gnt=10 (done_id=1). Repeat with both high -> order 0,1,0,1.
- rst_n low during RUN cycle 3 -> busy, done and hits go to 0 immediately and no done pulse occurs. After release, a new req completes normally.
- SSM_ABORT_EN defined, pat=8'hFF, len=8, abort in RUN cycle 5 -> next cycle done=1 and aborted=1, with hits=3 (z1 high in RUN cycles 3-5).
